// File: rtl/requant_ctrl.sv
// requant_ctrl: per-channel requantizer (in*scale >>> shift) with a run FSM and a two-stage elastic pipeline.
// Defining REQ_SAT_EN saturates the output to the signed DATA_WIDTH range instead of wrapping.
module requant_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int NUM_CH      = 8,
  localparam int CW         = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CW-1:0]          cfg_addr,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [4:0]             cfg_shift,
  input  logic                   start,
  input  logic [15:0]            len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy,
  output logic                   done
);
  localparam int PW = DATA_WIDTH + SCALE_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [CW-1:0] ch_q, ch_d;
  logic done_q, done_d;
  logic s1_v_q, s1_v_d, out_v_q, out_v_d;
  logic signed [PW-1:0] s1_prod_q, s1_prod_d, prod;
  logic [4:0] s1_sh_q, s1_sh_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, res;
  logic [SCALE_WIDTH-1:0] scale_mem [NUM_CH];
  logic [4:0] shift_mem [NUM_CH];
  logic s2_load, in_acc, out_hs;
  // Table has no reset; contents are undefined until written from IDLE.
  always_ff @(posedge clk)
    if (cfg_we && state_q == IDLE) begin
      scale_mem[cfg_addr] <= cfg_scale;
      shift_mem[cfg_addr] <= cfg_shift;
    end
  assign s2_load   = !out_v_q || out_ready;
  assign in_ready  = state_q == RUN && in_cnt_q < len_q && (!s1_v_q || s2_load);
  assign in_acc    = in_valid && in_ready;
  assign out_hs    = out_v_q && out_ready;
  assign prod      = $signed({{SCALE_WIDTH{in_data[DATA_WIDTH-1]}}, in_data})
                   * $signed({{DATA_WIDTH{scale_mem[ch_q][SCALE_WIDTH-1]}}, scale_mem[ch_q]});
  assign out_valid = out_v_q;
  assign out_data  = out_data_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
`ifdef REQ_SAT_EN
  localparam logic signed [PW-1:0] SMAX = {{(SCALE_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(SCALE_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic signed [PW-1:0] shifted;
  always_comb begin
    shifted = s1_prod_q >>> s1_sh_q;
    res = shifted > SMAX ? SMAX[DATA_WIDTH-1:0] :
          shifted < SMIN ? SMIN[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  end
`else
  assign res = DATA_WIDTH'(s1_prod_q >>> s1_sh_q);
`endif
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    ch_d       = ch_q;
    done_d     = 1'b0;
    s1_v_d     = in_acc ? 1'b1 : (s2_load ? 1'b0 : s1_v_q);
    s1_prod_d  = in_acc ? prod : s1_prod_q;
    s1_sh_d    = in_acc ? shift_mem[ch_q] : s1_sh_q;
    out_v_d    = s2_load ? s1_v_q : out_v_q;
    out_data_d = (s2_load && s1_v_q) ? res : out_data_q;
    case (state_q)
      IDLE:
        if (start) begin
          if (len != 16'd0) begin
            state_d   = RUN;
            len_d     = len;
            in_cnt_d  = 16'd0;
            out_cnt_d = 16'd0;
            ch_d      = '0;
          end else done_d = 1'b1;
        end
      RUN:
        if (in_acc) begin
          in_cnt_d = in_cnt_q + 16'd1;
          ch_d     = ch_q + CW'(1);
          if (in_cnt_q + 16'd1 == len_q) state_d = DRAIN;
        end
      default: ;
    endcase
    if (state_q != IDLE && out_hs) begin
      out_cnt_d = out_cnt_q + 16'd1;
      if (out_cnt_q + 16'd1 == len_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      ch_q       <= '0;
      done_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_prod_q  <= '0;
      s1_sh_q    <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      ch_q       <= ch_d;
      done_q     <= done_d;
      s1_v_q     <= s1_v_d;
      s1_prod_q  <= s1_prod_d;
      s1_sh_q    <= s1_sh_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
    end
endmodule
